// File: rtl/rr_arbiter_2b.sv
// ---------------------------------------------------------------------------
// rr_arbiter_2b
//
// Round-robin arbiter over four requesters. The winning requester index is
// registered and presented as a 2-bit select {o_sel_a, o_sel_b}. That select
// feeds a 2-to-4 decoder downstream, and o_gnt_valid qualifies the decoder
// output. A grant is held until the holder signals done, drops its request,
// or (optionally) exceeds MAX_HOLD cycles. After every release the arbiter
// spends at least one idle cycle, so two selects are never live back to back.
//
// Parameters
//   MAX_HOLD : max cycles a grant may be held before forced release (0 = none)
//   CNT_W    : hold counter width; choose so that 2**CNT_W > MAX_HOLD
//
// Ports
//   clk          in   1  clock, rising edge
//   rst_n        in   1  asynchronous active-low reset
//   i_req        in   4  request vector, i_req[i] = requester i
//   i_done       in   1  current holder finished; release this cycle
//   o_sel_a      out  1  grant index MSB (decoder input a)
//   o_sel_b      out  1  grant index LSB (decoder input b)
//   o_gnt_valid  out  1  select carries a live grant
//   o_timeout    out  1  one-cycle pulse: grant released by the hold limit only
//
// All outputs come straight from registers; none is combinational from inputs.
// ---------------------------------------------------------------------------
module rr_arbiter_2b #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] i_req,
    input  logic       i_done,
    output logic       o_sel_a,
    output logic       o_sel_b,
    output logic       o_gnt_valid,
    output logic       o_timeout
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Last counter value of a grant before the hold limit forces release.
    // The counter starts at 0 on the first grant cycle, so a limit of N
    // means release is decided in the cycle where the count reads N-1.
    localparam int                HOLD_LAST_I = (MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0;
    localparam logic [CNT_W-1:0]  HOLD_LAST   = CNT_W'(HOLD_LAST_I);
    localparam logic [CNT_W-1:0]  CNT_MAX     = '1;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t           r_state;
    logic [1:0]       r_sel;
    logic             r_gnt_valid;
    logic             r_timeout;
    logic [1:0]       r_ptr;
    logic [CNT_W-1:0] r_hold_cnt;

    state_t           w_state_next;
    logic [1:0]       w_sel_next;
    logic             w_gnt_valid_next;
    logic             w_timeout_next;
    logic [1:0]       w_ptr_next;
    logic [CNT_W-1:0] w_hold_cnt_next;

    // ------------------------------------------------------------------
    // Rotating priority search
    //
    // w_req_rot[k] is the request of requester (ptr + k) mod 4, so the
    // lowest set bit of w_req_rot is the first requester at or after ptr.
    // ------------------------------------------------------------------
    logic [3:0] w_req_rot;
    logic [1:0] w_pick_ofs;
    logic [1:0] w_pick_idx;
    logic       w_any_req;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rot
            assign w_req_rot[gi] = i_req[r_ptr + 2'(gi)];
        end
    endgenerate

    // Walk from the lowest priority slot upward so the lowest set offset
    // wins the final assignment.
    always_comb begin
        w_pick_ofs = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (w_req_rot[k]) begin
                w_pick_ofs = 2'(k);
            end
        end
    end

    assign w_any_req  = |i_req;
    assign w_pick_idx = r_ptr + w_pick_ofs;

    // ------------------------------------------------------------------
    // Release conditions for the current holder
    // ------------------------------------------------------------------
    logic w_holder_req;
    logic w_hold_limit;
    logic w_release;

    assign w_holder_req = i_req[r_sel];
    assign w_hold_limit = (MAX_HOLD != 0) && (r_hold_cnt == HOLD_LAST);
    assign w_release    = i_done || !w_holder_req || w_hold_limit;

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next     = r_state;
        w_sel_next       = r_sel;
        w_gnt_valid_next = r_gnt_valid;
        w_timeout_next   = 1'b0;
        w_ptr_next       = r_ptr;
        w_hold_cnt_next  = r_hold_cnt;

        unique case (r_state)
            ST_IDLE: begin
                w_gnt_valid_next = 1'b0;
                if (w_any_req) begin
                    w_state_next     = ST_GRANT;
                    w_sel_next       = w_pick_idx;
                    w_gnt_valid_next = 1'b1;
                    w_hold_cnt_next  = '0;
                end
            end

            ST_GRANT: begin
                if (r_hold_cnt != CNT_MAX) begin
                    w_hold_cnt_next = r_hold_cnt + CNT_W'(1);
                end
                if (w_release) begin
                    // Select stays on the old holder while idle; only the
                    // valid qualifier drops.
                    w_state_next     = ST_IDLE;
                    w_gnt_valid_next = 1'b0;
                    w_ptr_next       = r_sel + 2'd1;
                    // Flag the timeout only when nothing else would have
                    // ended the grant this cycle.
                    w_timeout_next   = w_hold_limit && !i_done && w_holder_req;
                end else begin
                    w_gnt_valid_next = 1'b1;
                end
            end

            default: begin
                w_state_next     = ST_IDLE;
                w_gnt_valid_next = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_sel       <= 2'd0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
            r_ptr       <= 2'd0;
            r_hold_cnt  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_sel       <= w_sel_next;
            r_gnt_valid <= w_gnt_valid_next;
            r_timeout   <= w_timeout_next;
            r_ptr       <= w_ptr_next;
            r_hold_cnt  <= w_hold_cnt_next;
        end
    end

    assign o_sel_a     = r_sel[1];
    assign o_sel_b     = r_sel[0];
    assign o_gnt_valid = r_gnt_valid;
    assign o_timeout   = r_timeout;

endmodule
